// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Owns the program counter, issues in-order 32-bit reads to instruction memory,
// buffers returned words with their PCs and hands them to decode over valid/ready.
// A redirect flushes everything and marks in-flight responses as stale.
// Optional feature: define IFU_MISALIGN_EN to flag misaligned redirects and
// stall fetch until an aligned redirect; without it redirect_pc[1:0] is forced to 0.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst
`ifdef IFU_MISALIGN_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [63:0]      fetch_pc;
    logic [63:0]      pcq [BUF_DEPTH];
    logic [PTR_W-1:0] pcq_rd;
    logic [PTR_W-1:0] pcq_wr;
    logic [63:0]      ibuf_pc   [BUF_DEPTH];
    logic [31:0]      ibuf_inst [BUF_DEPTH];
    logic [PTR_W-1:0] ibuf_rd;
    logic [PTR_W-1:0] ibuf_wr;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;

    logic             req_fire;
    logic             resp_keep;
    logic             id_fire;
    logic [CNT_W:0]   credit_used;
    logic [63:0]      resp_pc;
    logic [63:0]      redirect_target;
    logic             misalign_hold;
    logic [CNT_W-1:0] resp_dec;

`ifdef IFU_MISALIGN_EN
    logic misaligned;

    assign redirect_target  = redirect_pc;
    assign misalign_hold    = misaligned;
    assign fetch_misaligned = misaligned;

    // Sticky misaligned flag: every redirect re-evaluates it, so only an aligned one clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else if (redirect_valid) begin
            misaligned <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    // Low address bits are dropped so fetch always stays word aligned
    assign redirect_target = {redirect_pc[63:2], redirect_pc[1:0] & 2'b00};
    assign misalign_hold   = 1'b0;
`endif

    assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = rst_n && !redirect_valid && !misalign_hold &&
                            (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && (drop_cnt == '0);
    assign resp_dec       = CNT_W'(imem_resp_valid);

    assign id_valid = (buf_count != '0);
    assign id_pc    = ibuf_pc[ibuf_rd];
    assign id_inst  = ibuf_inst[ibuf_rd];
    assign id_fire  = id_valid && id_ready;

    // With no live request queued, a response can only belong to the request issued this same cycle
    assign resp_pc = (outstanding == drop_cnt) ? fetch_pc : pcq[pcq_rd];

    // Fetch PC, PC queue, instruction buffer and credit/drop bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            ibuf_rd     <= '0;
            ibuf_wr     <= '0;
            buf_count   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pcq[i]       <= '0;
                ibuf_pc[i]   <= '0;
                ibuf_inst[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_target;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            ibuf_rd     <= '0;
            ibuf_wr     <= '0;
            buf_count   <= '0;
            outstanding <= outstanding - resp_dec;
            drop_cnt    <= outstanding - resp_dec;
        end else begin
            if (req_fire) begin
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= pcq_wr + 1'b1;
                fetch_pc    <= fetch_pc + 64'd4;
            end
            if (imem_resp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (resp_keep) begin
                ibuf_pc[ibuf_wr]   <= resp_pc;
                ibuf_inst[ibuf_wr] <= imem_resp_data;
                ibuf_wr            <= ibuf_wr + 1'b1;
                pcq_rd             <= pcq_rd + 1'b1;
            end
            if (id_fire) begin
                ibuf_rd <= ibuf_rd + 1'b1;
            end
            buf_count   <= buf_count + CNT_W'(resp_keep) - CNT_W'(id_fire);
            outstanding <= outstanding + CNT_W'(req_fire) - resp_dec;
        end
    end

endmodule
